// File: rtl/chip_pkg.sv
// Shared definitions for the chip scheduler: state encoding, default sizes
// and the slot-index width helper.
package chip_pkg;

  localparam int NPROC_DEF  = 4;
  localparam int STEP_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  // A single process still needs a one-bit slot counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip_scheduler.sv
// Round-robin step scheduler: grants each process one slot per step, then
// checks the stop flags and the step limit before starting the next step.
module chip_scheduler
  import chip_pkg::*;
#(
  parameter int NPROC  = NPROC_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                start,
  input  logic [STEP_W-1:0]   maxSteps,
  input  logic [NPROC-1:0]    procStop,
  output logic                init,
  output logic [NPROC-1:0]    enable,
  output logic [3:0]          processCurrent,
  output logic signed [STEP_W:0] step,
  output logic                stepDone,
  output logic                running,
  output logic                done,
  output logic                returnCode,
  output logic [NPROC-1:0]    stopMask
);

  localparam int IDX_W = idx_width(NPROC);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NPROC - 1);
  localparam logic [NPROC-1:0] FIRST_GRANT = NPROC'(1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_slot;
  logic [STEP_W-1:0]     r_max;
  logic signed [STEP_W:0] r_step;
  logic                  r_init;
  logic [NPROC-1:0]      r_enable;
  logic                  r_step_done;
  logic                  r_running;
  logic                  r_done;
  logic                  r_return_code;
  logic [NPROC-1:0]      r_stop_mask;

  logic [STEP_W:0]       w_step_inc;
  logic                  w_limit_hit;

  // step is never negative in CHECK, so the limit test is a plain unsigned compare.
  assign w_step_inc  = $unsigned(r_step) + {{STEP_W{1'b0}}, 1'b1};
  assign w_limit_hit = (w_step_inc >= {1'b0, r_max});

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state       <= S_IDLE;
      r_slot        <= '0;
      r_max         <= '0;
      r_step        <= '0;
      r_init        <= 1'b0;
      r_enable      <= '0;
      r_step_done   <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_return_code <= 1'b0;
      r_stop_mask   <= '0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_INIT;
            r_max         <= maxSteps;
            r_stop_mask   <= '0;
            r_return_code <= 1'b0;
            r_init        <= 1'b1;
            r_step        <= '1;
            r_running     <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        S_INIT: begin
          r_init <= 1'b0;
          if (r_max == '0) begin
            r_state       <= S_DONE;
            r_return_code <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b1;
          end else begin
            r_state  <= S_RUN;
            r_step   <= '0;
            r_slot   <= '0;
            r_enable <= FIRST_GRANT;
          end
        end
        S_RUN: begin
          if (r_slot == LAST_SLOT) begin
            r_state     <= S_CHECK;
            r_enable    <= '0;
            r_step_done <= 1'b1;
          end else begin
            r_slot   <= r_slot + 1'b1;
            r_enable <= r_enable << 1;
          end
        end
        S_CHECK: begin
          // A process stop outranks the step limit.
          if (|procStop) begin
            r_state       <= S_DONE;
            r_return_code <= 1'b0;
            r_stop_mask   <= procStop;
            r_running     <= 1'b0;
            r_done        <= 1'b1;
          end else if (w_limit_hit) begin
            r_state       <= S_DONE;
            r_return_code <= 1'b1;
            r_stop_mask   <= '0;
            r_running     <= 1'b0;
            r_done        <= 1'b1;
          end else begin
            r_state  <= S_RUN;
            r_step   <= $signed(w_step_inc);
            r_slot   <= '0;
            r_enable <= FIRST_GRANT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign init           = r_init;
  assign enable         = r_enable;
  assign processCurrent = 4'(r_slot);
  assign step           = r_step;
  assign stepDone       = r_step_done;
  assign running        = r_running;
  assign done           = r_done;
  assign returnCode     = r_return_code;
  assign stopMask       = r_stop_mask;

endmodule

// File: tb/tb_chip_scheduler.sv
// Self-checking bench for chip_scheduler: a per-cycle expected trace is built
// from the scheduling rules, plus a scenario table and hand-written corner sequences.
module tb_chip_scheduler;

  localparam int NP = 4;
  localparam int SW = 8;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic              start = 1'b0;
  logic [SW-1:0]     maxSteps = '0;
  logic [NP-1:0]     procStop = '0;
  logic              init;
  logic [NP-1:0]     enable;
  logic [3:0]        processCurrent;
  logic signed [SW:0] step;
  logic              stepDone;
  logic              running;
  logic              done;
  logic              returnCode;
  logic [NP-1:0]     stopMask;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  chip_scheduler #(.NPROC(NP), .STEP_W(SW)) dut (
    .clock(clock), .resetN(resetN), .start(start), .maxSteps(maxSteps),
    .procStop(procStop), .init(init), .enable(enable),
    .processCurrent(processCurrent), .step(step), .stepDone(stepDone),
    .running(running), .done(done), .returnCode(returnCode), .stopMask(stopMask)
  );

  // pc = -1 means processCurrent is not meaningful in that cycle.
  typedef struct {
    logic          init;
    logic [NP-1:0] en;
    int            pc;
    int            step;
    logic          sd;
    logic          run;
    logic          dn;
    logic          rc;
    logic [NP-1:0] mask;
  } exp_t;

  typedef struct {
    string         name;
    int            mx;
    int            stop_step;
    logic [NP-1:0] smask;
    logic          rc;
    int            fstep;
    logic [NP-1:0] fmask;
    int            dcyc;
  } vec_t;

  exp_t          exp_q[$];
  logic [NP-1:0] ps_q[$];

  function automatic exp_t mk(logic i, logic [NP-1:0] en, int pc, int st, logic sd,
                              logic run, logic dn, logic rc, logic [NP-1:0] mask);
    exp_t e;
    e.init = i; e.en = en; e.pc = pc; e.step = st; e.sd = sd;
    e.run = run; e.dn = dn; e.rc = rc; e.mask = mask;
    return e;
  endfunction

  // Expected trace of one run, one entry per cycle after start is taken;
  // ps_q holds the procStop value driven during that cycle.
  function automatic void build(int mx, int stop_step, logic [NP-1:0] smask);
    logic [NP-1:0] ps;
    exp_q.delete();
    ps_q.delete();
    exp_q.push_back(mk(1'b1, '0, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, '0));
    ps_q.push_back(NP'($urandom));
    if (mx == 0) begin
      exp_q.push_back(mk(1'b0, '0, -1, -1, 1'b0, 1'b0, 1'b1, 1'b1, '0));
      ps_q.push_back(NP'($urandom));
      return;
    end
    for (int s = 0; s < 100000; s++) begin
      for (int p = 0; p < NP; p++) begin
        exp_q.push_back(mk(1'b0, NP'(1 << p), p, s, 1'b0, 1'b1, 1'b0, 1'b0, '0));
        ps_q.push_back(NP'($urandom));
      end
      ps = (s == stop_step) ? smask : '0;
      exp_q.push_back(mk(1'b0, '0, -1, s, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      ps_q.push_back(ps);
      if (ps != '0) begin
        exp_q.push_back(mk(1'b0, '0, -1, s, 1'b0, 1'b0, 1'b1, 1'b0, ps));
        ps_q.push_back(NP'($urandom));
        return;
      end
      if (s + 1 >= mx) begin
        exp_q.push_back(mk(1'b0, '0, -1, s, 1'b0, 1'b0, 1'b1, 1'b1, '0));
        ps_q.push_back(NP'($urandom));
        return;
      end
    end
  endfunction

  function automatic void check_cycle(exp_t e, string tag, int k);
    total++;
    if (init !== e.init || enable !== e.en || (e.pc >= 0 && processCurrent !== 4'(e.pc)) ||
        step !== (SW+1)'(e.step) || stepDone !== e.sd || running !== e.run ||
        done !== e.dn || returnCode !== e.rc || stopMask !== e.mask) begin
      bad++;
      $display("FAIL %s cyc%0d: got init=%b en=%b pc=%0d step=%0d sd=%b run=%b done=%b rc=%b mask=%b; want init=%b en=%b pc=%0d step=%0d sd=%b run=%b done=%b rc=%b mask=%b",
               tag, k, init, enable, processCurrent, step, stepDone, running, done,
               returnCode, stopMask, e.init, e.en, e.pc, e.step, e.sd, e.run, e.dn,
               e.rc, e.mask);
    end
  endfunction

  function automatic void check_int(string tag, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endfunction

  // Starts a run and compares every cycle against the trace; returns the
  // trace index at which done was first seen.
  task automatic run_scenario(input string tag, input int mx, input int stop_step,
                              input logic [NP-1:0] smask, input bit hold,
                              output int done_cyc);
    build(mx, stop_step, smask);
    @(negedge clock);
    start = 1'b1;
    maxSteps = SW'(mx);
    procStop = NP'($urandom);
    done_cyc = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      check_cycle(exp_q[k], tag, k);
      if (done === 1'b1 && done_cyc < 0) done_cyc = k;
      procStop = ps_q[k];
    end
    if (hold) begin
      @(negedge clock);
      check_cycle(mk(1'b1, '0, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, '0), {tag, "_restart"}, 0);
      start = 1'b0;
    end else begin
      repeat (2) begin
        @(negedge clock);
        procStop = NP'($urandom);
        check_cycle(exp_q[exp_q.size()-1], {tag, "_hold"}, exp_q.size());
      end
    end
    $display("run %s max=%0d stop_step=%0d rc=%b step=%0d mask=%b done_at=%0d",
             tag, mx, stop_step, returnCode, step, stopMask, done_cyc);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    resetN = 1'b0;
    start = 1'b0;
    #1;
    check_cycle(mk(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0), "reset_async", 0);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  vec_t vecs[7];
  exp_t reset_e;
  int dc;

  initial begin
    vecs[0] = '{"max3",      3,   -1, 4'b0000, 1'b1,  2, 4'b0000, 16};
    vecs[1] = '{"stop_s4",   100,  4, 4'b0100, 1'b0,  4, 4'b0100, 26};
    vecs[2] = '{"max0",      0,   -1, 4'b0000, 1'b1, -1, 4'b0000, 1};
    vecs[3] = '{"tie_max1",  1,    0, 4'b0001, 1'b0,  0, 4'b0001, 6};
    vecs[4] = '{"max1",      1,   -1, 4'b0000, 1'b1,  0, 4'b0000, 6};
    vecs[5] = '{"stop_s1",   2,    1, 4'b1010, 1'b0,  1, 4'b1010, 11};
    vecs[6] = '{"max255",    255, -1, 4'b0000, 1'b1, 254, 4'b0000, 1276};

    reset_e = mk(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clock);
    check_cycle(reset_e, "reset_state", 0);
    resetN = 1'b1;
    procStop = 4'b1111;
    @(negedge clock);
    check_cycle(reset_e, "idle_no_start", 0);

    for (int v = 0; v < 7; v++) begin
      run_scenario(vecs[v].name, vecs[v].mx, vecs[v].stop_step, vecs[v].smask, 1'b0, dc);
      check_int({vecs[v].name, "_rc"}, int'(returnCode), int'(vecs[v].rc));
      check_int({vecs[v].name, "_step"}, int'(step), vecs[v].fstep);
      check_int({vecs[v].name, "_mask"}, int'(stopMask), int'(vecs[v].fmask));
      check_int({vecs[v].name, "_done_cycle"}, dc, vecs[v].dcyc);
    end

    // Reset asserted during RUN slot 2, then a fresh run from step -1.
    build(10, -1, '0);
    @(negedge clock);
    start = 1'b1;
    maxSteps = SW'(10);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      start = 1'b0;
      check_cycle(exp_q[k], "pre_reset", k);
      procStop = ps_q[k];
      if (exp_q[k].pc == 2 && exp_q[k].step == 1) break;
    end
    #1;
    resetN = 1'b0;
    #1;
    check_cycle(reset_e, "midrun_reset", 0);
    @(negedge clock);
    check_cycle(reset_e, "midrun_reset_held", 1);
    resetN = 1'b1;
    run_scenario("after_reset", 2, -1, '0, 1'b0, dc);

    // start held high for the whole run must only restart from DONE.
    run_scenario("start_held", 2, -1, '0, 1'b1, dc);
    pulse_reset();

    for (int r = 0; r < 15; r++) begin
      int mx, ss;
      logic [NP-1:0] sm;
      mx = $urandom_range(0, 12);
      ss = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 12);
      sm = NP'($urandom_range(1, 15));
      run_scenario($sformatf("rand%0d", r), mx, ss, sm, 1'b0, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_scheduler.md
CHIP_SCHEDULER -- requirements
Module: chip_scheduler

Interface
REQ-001 SHALL take parameter NPROC, default 4: number of processes scheduled, 1..16.
REQ-002 SHALL take parameter STEP_W, default 16: width of step counter and maxSteps.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetN, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a run; sampled only in IDLE or DONE.
REQ-006 SHALL have port maxSteps, input, STEP_W: step limit, sampled on the start cycle.
REQ-007 SHALL have port procStop, input, NPROC: per-process stop flags, bit i from process i.
REQ-008 SHALL have port init, output, 1: process register initialisation strobe (step -1).
REQ-009 SHALL have port enable, output, NPROC: one-hot grant; process i executes one instruction when bit i is high.
REQ-010 SHALL have port processCurrent, output, 4: index of the granted process.
REQ-011 SHALL have port step, output, STEP_W+1: signed current step; -1 during init.
REQ-012 SHALL have port stepDone, output, 1: one-cycle pulse after every process has had its slot in a step (trace print point).
REQ-013 SHALL have port running, output, 1: high in INIT, RUN and CHECK.
REQ-014 SHALL have port done, output, 1: high in DONE.
REQ-015 SHALL have port returnCode, output, 1: 0 when stopped by a process, 1 when maxSteps was exhausted.
REQ-016 SHALL have port stopMask, output, NPROC: procStop captured on the terminating CHECK cycle.

Function
REQ-017 SHALL implement states IDLE, INIT, RUN, CHECK, DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to INIT, latch maxSteps, and clear stopMask and returnCode.
REQ-019 INIT SHALL last exactly one cycle, with init=1, step=-1 and enable=0.
REQ-020 INIT SHALL go to CHECK-bypass: if latched maxSteps==0 go to DONE with returnCode=1; otherwise go to RUN with step=0 and slot=0.
REQ-021 RUN SHALL last NPROC cycles, one per process in ascending index, with enable=1<<slot and processCurrent=slot.
REQ-022 RUN SHALL go to CHECK after slot NPROC-1; each step therefore takes NPROC+1 cycles.
REQ-023 CHECK SHALL assert stepDone=1 and enable=0, with step still showing the completed step.
REQ-024 In CHECK, if |procStop, the block SHALL go to DONE with returnCode=0 and stopMask=procStop. Stop has priority over the limit.
REQ-025 Otherwise in CHECK, if step+1 >= maxSteps, the block SHALL go to DONE with returnCode=1 and stopMask=0.
REQ-026 Otherwise in CHECK, the block SHALL increment step and go to RUN with slot=0.
REQ-027 DONE SHALL hold step, returnCode and stopMask until the next start or reset.
REQ-028 start SHALL be ignored in INIT, RUN and CHECK; procStop SHALL be ignored outside CHECK.
REQ-029 step SHALL NOT wrap; maxSteps up to 2^STEP_W-1 SHALL be reachable.

Reset
REQ-030 resetN low SHALL immediately force IDLE, including mid-run.
REQ-031 Reset SHALL clear outputs: init=0, enable=0, processCurrent=0, step=0, stepDone=0, running=0, done=0, returnCode=0, stopMask=0.

Structure
REQ-032 The state enum, the CLOG-based index width and the default NPROC/STEP_W SHALL live in shared package chip_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the slot counter and step counter SHALL be inline.

Verification
REQ-034 Scenario: NPROC=4, maxSteps=3, procStop=0 -> init for 1 cycle; enable sequence 1,2,4,8 repeated 3 times; 3 stepDone pulses with step=0,1,2; done with returnCode=1 after 1+15 cycles.
REQ-035 Scenario: maxSteps=100, procStop[2] raised during step 4 -> DONE at step 4's CHECK; returnCode=0; stopMask=4'b0100; step=4.
REQ-036 Scenario: maxSteps=0 -> INIT then DONE; enable never asserted; returnCode=1; no stepDone.
REQ-037 Scenario: procStop=1 and the limit are reached in the same CHECK (maxSteps=1) -> returnCode=0.
REQ-038 Scenario: resetN pulsed low in RUN slot 2 -> outputs cleared asynchronously; IDLE; start afterwards reruns from step -1.
REQ-039 Scenario: start held high throughout the run -> ignored until DONE, then a new run begins with the next INIT.
